// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: fetch/decode handshake bundle for instr_fetch_queue.
// master = pipeline side driving fetch entries and decode ready; slave = the queue.
interface instr_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     if_valid;
  logic                     if_ready;
  logic [XLEN-1:0]          if_pc;
  logic [31:0]              if_instr;
  logic                     id_valid;
  logic                     id_ready;
  logic [XLEN-1:0]          id_pc;
  logic [31:0]              id_instr;
  logic                     id_misaligned;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output flush, if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_misaligned, count
  );
  modport slave (
    input  flush, if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_misaligned, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: circular fetch-to-decode queue with flush; define IFQ_BYPASS_EN
// to present an incoming entry combinationally when the queue is empty.
module instr_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rstn,
  instr_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic            r_mis   [DEPTH];
  logic            w_empty, w_full, w_byp, w_push, w_pop;
  logic            w_in_mis;
  logic [AW-1:0]   w_rd_idx;
  assign w_rd_idx = r_rd_ptr[AW-1:0];
  assign w_empty  = r_wr_ptr == r_rd_ptr;
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_in_mis = bus.if_pc[1:0] != 2'b00;
`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty & bus.if_valid & ~bus.flush;
`else
  assign w_byp = 1'b0;
`endif
  // A bypassed entry taken by decode the same cycle never enters storage.
  assign w_push = bus.if_valid & ~w_full & ~bus.flush & ~(w_byp & bus.id_ready);
  assign w_pop  = ~w_empty & bus.id_ready & ~bus.flush;
  assign bus.if_ready = ~w_full;
  assign bus.count    = r_wr_ptr - r_rd_ptr;
  always_comb begin
    bus.id_valid      = ~w_empty | w_byp;
    bus.id_pc         = w_byp ? bus.if_pc    : w_empty ? '0    : r_pc[w_rd_idx];
    bus.id_instr      = w_byp ? bus.if_instr : w_empty ? 32'h0 : r_instr[w_rd_idx];
    bus.id_misaligned = w_byp ? w_in_mis     : w_empty ? 1'b0  : r_mis[w_rd_idx];
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && w_push) begin
      r_pc[r_wr_ptr[AW-1:0]]    <= bus.if_pc;
      r_instr[r_wr_ptr[AW-1:0]] <= bus.if_instr;
      r_mis[r_wr_ptr[AW-1:0]]   <= w_in_mis;
    end
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Decoupling queue between the instruction fetch stage and the decode stage of the RV32I pipeline. It accepts (PC, instruction) pairs from fetch through a valid/ready handshake, buffers up to DEPTH of them in a circular buffer, and presents them in order to decode. It absorbs decode stalls without stalling fetch and discards all buffered entries on a pipeline redirect (flush).

## Interface

Parameters:
- XLEN, 32, width of program counter.
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- flush  in  1  discard all entries (branch/jump redirect).
- if_valid  in  1  fetch presents an entry.
- if_ready  out  1  queue can accept an entry.
- if_pc  in  XLEN  PC of incoming instruction.
- if_instr  in  32  incoming instruction word.
- id_valid  out  1  head entry available to decode.
- id_ready  in  1  decode consumes head entry.
- id_pc  out  XLEN  PC of head entry.
- id_instr  out  32  instruction of head entry.
- id_misaligned  out  1  head entry PC has PC[1:0] ≠ 0.
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.

## Operation

- Storage: DEPTH entries of {pc, instr, misaligned}. Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty.
- Pointers wrap modulo DEPTH.
- empty = (wr_ptr == rd_ptr). full = index bits equal and MSBs differ.
- if_ready = !full. This is combinational from state only and never depends on id_ready.
  - A pop in the same cycle does not free a slot for a same-cycle push.
- push = if_valid & if_ready & !flush. Writes the entry at wr_ptr and increments wr_ptr.
- pop = id_valid & id_ready & !flush. Increments rd_ptr.
- Simultaneous push and pop when not full: both happen and count is unchanged.
- misaligned bit = (if_pc[1:0] != 2'b00), captured at push.
- id_valid = !empty. id_pc, id_instr and id_misaligned come from the entry at rd_ptr.
  - When id_valid = 0, all three are driven to 0.
- count = wr_ptr − rd_ptr (modulo 2·DEPTH).
- flush has priority over push and pop:
  - Both pointers are set to 0 at the next edge.
  - Any fetch entry offered in the flush cycle is dropped.
  - Any decode handshake in the flush cycle does not count as a pop.
- Output contract: once id_valid is asserted, id_pc and id_instr stay stable until a pop or a flush.
- Reset (rstn = 0 at a clock edge) clears both pointers.
  - Storage contents are not reset.
  - Reset has priority over flush, push and pop.

## Timing

- Reset values: id_valid 0, id_pc 0, id_instr 0, id_misaligned 0, count 0, if_ready 1 (from the first cycle after the reset edge).
- Latency without bypass: an entry pushed at edge N is visible with id_valid = 1 after edge N (one cycle).
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Flush asserted in cycle N: after edge N, id_valid = 0, count = 0, if_ready = 1.
- Reset mid-operation: the same outcome as flush on the next edge, regardless of other inputs.

## Configuration

- IFQ_BYPASS_EN defined:
  - When empty and if_valid & !flush, the incoming entry is presented on the id_* outputs in the same cycle (id_valid = 1 combinationally).
  - If id_ready = 1 in that cycle, the entry is consumed and is not written; count remains 0.
  - If id_ready = 0, the entry is written normally and appears from storage on the next cycle. Outputs stay unchanged, so the stability contract holds.
  - if_ready is unaffected by bypass.
- IFQ_BYPASS_EN undefined: id_valid depends only on registered state, and the minimum latency is one cycle.

## Test plan

- Reset then idle: rstn low for 2 cycles → id_valid 0, id_pc 0, count 0, if_ready 1.
- Fill and stall: push PC 0x0, 0x4, 0x8, 0xC with id_ready = 0 (DEPTH = 4) → count 4, if_ready 0. A fifth push of 0x10 is not accepted and id_pc stays 0x0.
- Drain in order: from the full state, id_ready = 1 for 4 cycles → id_pc sequence 0x0, 0x4, 0x8, 0xC, then id_valid 0 and count 0.
- Streaming and wrap: continuous push and pop of 10 sequential PCs from 0x100 with id_ready always 1 →
  - id_pc 0x100..0x124 in order, one per cycle, no drops or duplicates.
  - Pointers wrap twice.
  - Without bypass, the first output appears one cycle after the first push.
- Flush mid-stream: count 3, then flush = 1 with if_valid = 1 (PC 0x200) and id_ready = 1 → next cycle count 0, id_valid 0, and 0x200 is never emitted.
- Misaligned and bypass: push PC 0x302 → id_misaligned 1. With IFQ_BYPASS_EN, an empty queue, if_valid = 1 (PC 0x400) and id_ready = 1 → id_valid 1 and id_pc 0x400 in the same cycle, with count staying 0.
